// File: rtl/channel_capture_ctrl.sv
// Capture controller for the logic-analyzer sample RAMs: circular write pointer,
// guaranteed pre-trigger window, programmable post-trigger count and oldest-first readout.
module channel_capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9,
  parameter int NCH     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            stop,
  input  logic            auto,
  input  logic            wrt_smpl,
  input  logic            triggered,
  input  logic [LOG2-1:0] trig_pos,
  input  logic [NCH-1:0]  ch_en,
  input  logic            start_rd,
  input  logic            rd_en,
  output logic [NCH-1:0]  we,
  output logic [LOG2-1:0] waddr,
  output logic [LOG2-1:0] raddr,
  output logic [LOG2-1:0] trig_addr,
  output logic            armed,
  output logic            capture_done,
  output logic            read_done
);

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    ARMED,
    POST,
    DONE,
    DUMP
  } state_t;

  localparam logic [LOG2:0]   ENT       = (LOG2+1)'(ENTRIES);
  localparam logic [LOG2:0]   CNT_ONE   = (LOG2+1)'(1);
  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);

  state_t          state_q, state_d;
  logic [LOG2-1:0] waddr_q, waddr_d;
  logic [LOG2-1:0] raddr_q, raddr_d;
  logic [LOG2-1:0] trig_addr_q, trig_addr_d;
  logic [LOG2:0]   pre_cnt_q, pre_cnt_d;
  logic [LOG2:0]   post_cnt_q, post_cnt_d;
  logic [LOG2:0]   rd_cnt_q, rd_cnt_d;
  logic [LOG2:0]   p_q, p_d;
  logic            read_done_q, read_done_d;

  logic [LOG2:0]   p_req;
  logic [LOG2:0]   pre_inc;
  logic [LOG2:0]   post_inc;
  logic [LOG2:0]   rd_inc;

  function automatic logic [LOG2-1:0] wrap_inc(input logic [LOG2-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + LOG2'(1);
  endfunction

  // Requested post-trigger count, forced into the legal range 1..ENTRIES.
  always_comb begin
    if (trig_pos == '0) begin
      p_req = CNT_ONE;
    end else if ({1'b0, trig_pos} >= ENT) begin
      p_req = ENT;
    end else begin
      p_req = {1'b0, trig_pos};
    end
  end

  assign pre_inc  = pre_cnt_q + CNT_ONE;
  assign post_inc = post_cnt_q + CNT_ONE;
  assign rd_inc   = rd_cnt_q + CNT_ONE;

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    trig_addr_d = trig_addr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    p_d         = p_q;
    read_done_d = 1'b0;
    we          = '0;

    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            p_d        = p_req;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            waddr_d    = '0;
            state_d    = (p_req == ENT) ? ARMED : PRETRIG;
          end
        end

        PRETRIG: begin
          if (wrt_smpl) begin
            we        = ch_en;
            waddr_d   = wrap_inc(waddr_q);
            pre_cnt_d = pre_inc;
            if (pre_inc == ENT - p_q) begin
              state_d = ARMED;
            end
          end
        end

        ARMED: begin
          if (wrt_smpl) begin
            we      = ch_en;
            waddr_d = wrap_inc(waddr_q);
            if (triggered) begin
              trig_addr_d = waddr_q;
              post_cnt_d  = CNT_ONE;
              state_d     = (p_q == CNT_ONE) ? DONE : POST;
            end
          end
        end

        POST: begin
          if (wrt_smpl) begin
            we         = ch_en;
            waddr_d    = wrap_inc(waddr_q);
            post_cnt_d = post_inc;
            if (post_inc == p_q) begin
              state_d = DONE;
            end
          end
        end

        DONE: begin
          // The next write slot holds the oldest sample of the circular buffer.
          if (start_rd) begin
            raddr_d  = waddr_q;
            rd_cnt_d = '0;
            state_d  = DUMP;
          end
        end

        DUMP: begin
          if (rd_en) begin
            raddr_d  = wrap_inc(raddr_q);
            rd_cnt_d = rd_inc;
            if (rd_inc == ENT) begin
              read_done_d = 1'b1;
              if (auto && run) begin
                pre_cnt_d  = '0;
                post_cnt_d = '0;
                waddr_d    = '0;
                state_d    = (p_q == ENT) ? ARMED : PRETRIG;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      waddr_q     <= '0;
      raddr_q     <= '0;
      trig_addr_q <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      p_q         <= CNT_ONE;
      read_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      trig_addr_q <= trig_addr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      p_q         <= p_d;
      read_done_q <= read_done_d;
    end
  end

  assign waddr        = waddr_q;
  assign raddr        = raddr_q;
  assign trig_addr    = trig_addr_q;
  assign armed        = (state_q == ARMED);
  assign capture_done = (state_q == DONE) || (state_q == DUMP);
  assign read_done    = read_done_q;

endmodule

// File: tb/tb_channel_capture_ctrl.sv
// Bench for channel_capture_ctrl: table-driven capture scenarios, directed corner
// sequences, then randomized traffic against a count-based reference model.
module tb_channel_capture_ctrl;

  localparam int E  = 384;
  localparam int LG = 9;
  localparam int NC = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0, stop = 1'b0, auto_i = 1'b0;
  logic          wrt_smpl = 1'b0, triggered = 1'b0;
  logic [LG-1:0] trig_pos = '0;
  logic [NC-1:0] ch_en = '0;
  logic          start_rd = 1'b0, rd_en = 1'b0;
  logic [NC-1:0] we;
  logic [LG-1:0] waddr, raddr, trig_addr;
  logic          armed, capture_done, read_done;

  int n_checks = 0;
  int n_errors = 0;

  channel_capture_ctrl #(.ENTRIES(E), .LOG2(LG), .NCH(NC)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .stop(stop), .auto(auto_i),
    .wrt_smpl(wrt_smpl), .triggered(triggered), .trig_pos(trig_pos),
    .ch_en(ch_en), .start_rd(start_rd), .rd_en(rd_en), .we(we),
    .waddr(waddr), .raddr(raddr), .trig_addr(trig_addr), .armed(armed),
    .capture_done(capture_done), .read_done(read_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 0; stop = 0; auto_i = 0; wrt_smpl = 0; triggered = 0;
    start_rd = 0; rd_en = 0; trig_pos = '0; ch_en = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Starts (or continues) a capture with wrt_smpl every cycle until capture_done.
  task automatic do_capture(input logic [LG-1:0] tp, input logic [NC-1:0] mask,
                            input int trig_at, output int nw, output int arm_at,
                            output int we_bad);
    trig_pos = tp; ch_en = mask; run = 1; wrt_smpl = 0; triggered = 0;
    tick();
    nw = 0; we_bad = 0;
    arm_at = (armed === 1'b1) ? 0 : -1;
    for (int g = 0; g < 1200 && capture_done !== 1'b1; g++) begin
      wrt_smpl = 1;
      triggered = (trig_at == 0) || (nw + 1 >= trig_at);
      #1;
      if (we !== mask) we_bad++;
      tick();
      nw++;
      if (armed === 1'b1 && arm_at < 0) arm_at = nw;
    end
    wrt_smpl = 0; triggered = 0;
  endtask

  task automatic do_readout(input int base, output int addr_bad, output int done_bad);
    addr_bad = 0; done_bad = 0;
    start_rd = 1;
    tick();
    start_rd = 0;
    if (raddr !== LG'(base)) addr_bad++;
    for (int i = 1; i <= E; i++) begin
      rd_en = 1;
      tick();
      if (raddr !== LG'((base + i) % E)) addr_bad++;
      if (i < E) begin
        if (read_done !== 1'b0 || capture_done !== 1'b1) done_bad++;
      end else begin
        if (read_done !== 1'b1 || capture_done !== 1'b0) done_bad++;
      end
    end
    rd_en = 0;
    tick();
    if (read_done !== 1'b0) done_bad++;
  endtask

  typedef struct {
    logic [LG-1:0] tp;
    logic [NC-1:0] mask;
    int            trig_at;
    int            exp_arm;
    int            exp_total;
    int            exp_taddr;
    int            exp_waddr;
  } vec_t;

  vec_t vecs[6];

  // Reference model: counts since capture start, no state encoding.
  int unsigned m_writes, m_post, m_reads, m_p, m_rbase;
  bit          m_cap, m_hit, m_cmpl, m_rd, m_rdone;
  logic [LG-1:0] m_taddr, m_raddr;

  task automatic model_init();
    m_writes = 0; m_post = 0; m_reads = 0; m_p = 1; m_rbase = 0;
    m_cap = 0; m_hit = 0; m_cmpl = 0; m_rd = 0; m_rdone = 0;
    m_taddr = '0; m_raddr = '0;
  endtask

  task automatic model_start();
    m_cap = 1; m_writes = 0; m_hit = 0; m_post = 0;
  endtask

  task automatic model_step();
    int unsigned tp;
    m_rdone = 0;
    if (stop) begin
      m_cap = 0; m_cmpl = 0; m_rd = 0;
    end else if (!m_cap && !m_cmpl) begin
      if (run) begin
        tp = trig_pos;
        m_p = (tp == 0) ? 1 : ((tp >= E) ? E : tp);
        model_start();
      end
    end else if (m_cap) begin
      if (wrt_smpl) begin
        if (!m_hit && triggered && m_writes + m_p >= E) begin
          m_hit = 1; m_taddr = LG'(m_writes % E); m_post = 0;
        end
        if (m_hit) m_post++;
        m_writes++;
        if (m_hit && m_post == m_p) begin
          m_cap = 0; m_cmpl = 1;
        end
      end
    end else if (!m_rd) begin
      if (start_rd) begin
        m_rd = 1; m_reads = 0; m_rbase = m_writes % E; m_raddr = LG'(m_rbase);
      end
    end else if (rd_en) begin
      m_reads++;
      m_raddr = LG'((m_rbase + m_reads) % E);
      if (m_reads == E) begin
        m_rd = 0; m_cmpl = 0; m_rdone = 1;
        if (auto_i && run) model_start();
      end
    end
  endtask

  initial begin
    int nw, arm_at, we_bad, addr_bad, done_bad, tp_sel;
    logic [NC-1:0] exp_we;
    logic m_armed;

    vecs[0] = '{9'd100, 5'h1F,    300, 284, 399, 299, 15};
    vecs[1] = '{9'd10,  5'b00101, 0,   374, 384, 374, 0};
    vecs[2] = '{9'd0,   5'h1F,    0,   383, 384, 383, 0};
    vecs[3] = '{9'd511, 5'h1F,    0,   0,   384, 0,   0};
    vecs[4] = '{9'd384, 5'b10010, 5,   0,   388, 4,   4};
    vecs[5] = '{9'd383, 5'h1F,    0,   1,   384, 1,   0};

    // Reset values
    rst_n = 1'b0;
    wrt_smpl = 1; ch_en = '1;
    #7;
    check("reset_outputs", {waddr, raddr, trig_addr, armed, capture_done, read_done}, '0);
    check("reset_we", 32'(we), 32'd0);
    do_reset();

    // Table-driven capture scenarios
    for (int v = 0; v < 6; v++) begin
      do_reset();
      do_capture(vecs[v].tp, vecs[v].mask, vecs[v].trig_at, nw, arm_at, we_bad);
      check($sformatf("vec%0d_arm_at", v), 32'(arm_at), 32'(vecs[v].exp_arm));
      check($sformatf("vec%0d_total_writes", v), 32'(nw), 32'(vecs[v].exp_total));
      check($sformatf("vec%0d_trig_addr", v), 32'(trig_addr), 32'(vecs[v].exp_taddr));
      check($sformatf("vec%0d_waddr", v), 32'(waddr), 32'(vecs[v].exp_waddr));
      check($sformatf("vec%0d_we_mask_errs", v), 32'(we_bad), 32'd0);
      check($sformatf("vec%0d_flags", v), {armed, capture_done}, 2'b01);
      wrt_smpl = 1; #1;
      check($sformatf("vec%0d_no_write_in_done", v), 32'(we), 32'd0);
      wrt_smpl = 0;
    end

    // Single-shot readout with wrapping addresses
    do_reset();
    do_capture(9'd100, 5'h1F, 300, nw, arm_at, we_bad);
    run = 0;
    do_readout(15, addr_bad, done_bad);
    check("single_raddr_walk_errs", 32'(addr_bad), 32'd0);
    check("single_read_done_errs", 32'(done_bad), 32'd0);
    wrt_smpl = 1; #1;
    check("single_idle_no_write", 32'(we), 32'd0);
    check("single_idle_flags", {armed, capture_done}, 2'b00);
    wrt_smpl = 0;

    // Auto re-arm with run held
    do_reset();
    auto_i = 1;
    do_capture(9'd0, 5'h1F, 0, nw, arm_at, we_bad);
    check("auto_capture_done", 32'(capture_done), 32'd1);
    do_readout(0, addr_bad, done_bad);
    check("auto_read_errs", 32'(addr_bad + done_bad), 32'd0);
    check("auto_waddr_cleared", 32'(waddr), 32'd0);
    wrt_smpl = 1; #1;
    check("auto_pretrig_write", 32'(we), 32'h1F);
    tick();
    check("auto_waddr_advance", 32'(waddr), 32'd1);
    wrt_smpl = 0; auto_i = 0;

    // stop during POST, with run held
    do_reset();
    trig_pos = 9'd100; ch_en = 5'h1F; run = 1;
    tick();
    wrt_smpl = 1; triggered = 1;
    repeat (290) tick();
    check("post_waddr", 32'(waddr), 32'd290);
    check("post_flags", {armed, capture_done}, 2'b00);
    stop = 1; #1;
    check("stop_we_forced", 32'(we), 32'd0);
    tick();
    stop = 0; run = 0; #1;
    check("stop_post_flags", {armed, capture_done, read_done}, 3'b000);
    check("stop_post_waddr_held", 32'(waddr), 32'd290);
    check("stop_post_idle_we", 32'(we), 32'd0);
    wrt_smpl = 0; triggered = 0;

    // stop during DUMP
    do_reset();
    do_capture(9'd1, 5'h1F, 0, nw, arm_at, we_bad);
    run = 0;
    start_rd = 1; tick(); start_rd = 0;
    rd_en = 1;
    repeat (10) tick();
    check("dump_capture_done", 32'(capture_done), 32'd1);
    stop = 1; start_rd = 1;
    tick();
    stop = 0; rd_en = 0; start_rd = 0;
    check("stop_dump_flags", {armed, capture_done, read_done}, 3'b000);
    check("stop_dump_raddr", 32'(raddr), 32'd10);

    // Asynchronous reset in the middle of a capture
    do_reset();
    trig_pos = 9'd100; ch_en = 5'h1F; run = 1;
    tick();
    wrt_smpl = 1;
    repeat (50) tick();
    check("mid_waddr", 32'(waddr), 32'd50);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {waddr, raddr, trig_addr, armed, capture_done, read_done}, '0);
    check("async_reset_we", 32'(we), 32'd0);
    wrt_smpl = 0;

    // Randomized traffic against the reference model
    do_reset();
    model_init();
    for (int c = 0; c < 30000 && n_errors < 20; c++) begin
      run       = ($urandom_range(0, 9) != 0);
      stop      = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 199) == 0) auto_i = ~auto_i;
      wrt_smpl  = ($urandom_range(0, 3) != 0);
      triggered = ($urandom_range(0, 15) == 0);
      ch_en     = NC'($urandom);
      start_rd  = ($urandom_range(0, 7) == 0);
      rd_en     = ($urandom_range(0, 3) != 0);
      tp_sel    = $urandom_range(0, 7);
      case (tp_sel)
        0: trig_pos = 9'd0;
        1: trig_pos = 9'd1;
        2: trig_pos = 9'd383;
        3: trig_pos = 9'd384;
        4: trig_pos = 9'd511;
        default: trig_pos = LG'($urandom);
      endcase
      #1;
      exp_we = (m_cap && wrt_smpl && !stop) ? ch_en : '0;
      check("rand_we", 32'(we), 32'(exp_we));
      model_step();
      tick();
      m_armed = m_cap && !m_hit && (m_writes + m_p >= E);
      check("rand_regs", {waddr, raddr, trig_addr, armed, capture_done, read_done},
            {LG'(m_writes % E), m_raddr, m_taddr, m_armed, m_cmpl, m_rdone});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/channel_capture_ctrl.md
# channel_capture_ctrl

Second-generation capture controller for the logic-analyzer sample RAMs. It manages one circular write pointer shared by `NCH` channel RAMs and guarantees a full pre-trigger window before it accepts a trigger. It counts a programmable number of post-trigger samples, then supports a sequential oldest-first readout. Added over the previous generation: per-channel write enables, single/auto re-arm mode, abort, trigger-address capture, and safe clamping of the trigger position.

## Interface

Parameters:
- `ENTRIES`, 384: RAM depth in samples (12288 on DE-0); any value from 2 to 2^LOG2.
- `LOG2`, 9: address width; must satisfy 2^LOG2 >= ENTRIES.
- `NCH`, 5: number of channel RAMs driven.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `run` in 1: level; starts capture from IDLE.
- `stop` in 1: abort; highest priority.
- `auto` in 1: 1 = re-arm after readout if `run` is still high; 0 = single shot.
- `wrt_smpl` in 1: sample strobe from the decimator.
- `triggered` in 1: trigger from the trigger logic.
- `trig_pos` in LOG2: number of post-trigger samples requested.
- `ch_en` in NCH: channel write mask.
- `start_rd` in 1: begin readout.
- `rd_en` in 1: advance the read pointer by one.
- `we` out NCH: RAM write enables (combinational).
- `waddr` out LOG2: write address (registered).
- `raddr` out LOG2: read address (registered).
- `trig_addr` out LOG2: address of the trigger sample.
- `armed` out 1: pre-trigger window full.
- `capture_done` out 1: level; capture complete, data readable.
- `read_done` out 1: one-cycle pulse at end of readout.

## Operation

- **Post-trigger count P.** P = `trig_pos`, with 0 treated as 1 and values >= ENTRIES clamped to ENTRIES. P is sampled when leaving IDLE and held.
- **Pre-trigger count.** Pre-trigger samples required = ENTRIES - P.
- **Counter widths.** All counters are LOG2+1 bits, so a power-of-two ENTRIES cannot overflow.
- **States.** IDLE, PRETRIG, ARMED, POST, DONE, DUMP.
- **IDLE.**
  - On `run`: go to PRETRIG, clear the pre/post counters and `waddr`.
  - If P == ENTRIES, go straight to ARMED.
- **Write rule.** In PRETRIG, ARMED and POST, each `wrt_smpl` asserts `we` = `ch_en` and advances `waddr`. `waddr` wraps from ENTRIES-1 to 0.
- **PRETRIG.**
  - Count the writes. On the write that makes the count equal ENTRIES - P, go to ARMED; `armed`=1 from the next cycle.
  - `triggered` is ignored in this state.
- **ARMED.**
  - On `wrt_smpl` with `triggered`: latch the current `waddr` into `trig_addr`. This write is post-trigger sample 1.
  - If P == 1, go to DONE; otherwise go to POST.
  - `triggered` without `wrt_smpl` is not latched.
- **POST.**
  - Count the writes. On the write that brings the total to P, go to DONE.
  - `triggered` is ignored in this state.
- **DONE.**
  - `capture_done`=1 and `armed`=0. No writes occur.
  - On `start_rd`: load `raddr` = `waddr` (the oldest sample) and go to DUMP.
- **DUMP.**
  - Each `rd_en` advances `raddr` with wrap and increments a read counter.
  - On the rd_en that makes the read count ENTRIES: pulse `read_done` and clear `capture_done`.
  - Then go to PRETRIG if `auto` and `run` are both high (with counters and `waddr` cleared); otherwise go to IDLE.
  - `capture_done` stays 1 throughout DUMP until that final rd_en.
- **stop.** From any state, go to IDLE next cycle with `armed`, `capture_done` and `we` forced 0. `stop` beats `run`, `start_rd` and `triggered` in the same cycle.
- **`ch_en` all zero.** Pointers and counters still advance; only the RAM writes are suppressed.

## Timing

- **Reset values.** state IDLE; `waddr`=0, `raddr`=0, `trig_addr`=0; `armed`=0, `capture_done`=0, `read_done`=0, `we`=0.
- **`we`.** Same-cycle combinational from `wrt_smpl`. `waddr` updates on the following edge, so the RAM writes at the pre-increment address.
- **`armed`.** Rises the cycle after the final pre-trigger write. A `triggered` coinciding with that write is ignored.
- **`capture_done`.** Rises the cycle after the P-th post-trigger write.
- **`raddr`.** Valid the cycle after `start_rd`; data latency is owned by the RAM.
- **`read_done`.** Asserted in the cycle following the final `rd_en` edge, for exactly one cycle.
- **Mid-operation reset.** Asynchronous assertion of `rst_n` returns every output to its reset value immediately.

## Test plan

- **Basic capture.** ENTRIES=384, `trig_pos`=100, `run`=1, `wrt_smpl` every cycle, `triggered` at sample 300.
  - `armed` rises after write 284.
  - `trig_addr`=299.
  - `capture_done` rises after 100 post-trigger writes.
  - `waddr`=15 (wrapped).
- **Early trigger.** `triggered` held high from cycle 0 with `trig_pos`=10: no latch until 374 writes have completed, then `trig_addr`=374.
- **Readout.** From DONE, `start_rd` gives `raddr`=`waddr`. 384 `rd_en` pulses walk the addresses with wrap. `read_done` fires for exactly one cycle; `capture_done` then drops.
- **Clamping.**
  - `trig_pos`=0: captures 1 post-trigger sample.
  - `trig_pos`=511: ARMED immediately after `run`; 384 post-trigger writes.
- **Auto vs single.**
  - `auto`=1 with `run` held: returns to PRETRIG after `read_done`.
  - `auto`=0: returns to IDLE.
- **Abort and masking.**
  - `stop` asserted in POST and in DUMP: IDLE next cycle with all flags 0.
  - `ch_en`=5'b00101: `we` asserts only bits 0 and 2.
